// File: rtl/sprite_compositor.sv
// sprite_compositor: 2-stage goose/obstacle/floor/sky pixel compositor with a sticky collision report.
// Optional floor shadow under a jumping goose is enabled by defining COMPOSITOR_SHADOW_EN.
module sprite_compositor #(
  parameter int N_OBST      = 3,
  parameter int GOOSE_SCALE = 1,
  parameter int GOOSE_X     = 64,
  parameter int FLOOR_Y     = 240,
  parameter int OBST_W      = 40,
  parameter int OBST_H      = 48,
  parameter int DOT_LOG2    = 4
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic                   display_on,
  input  logic [9:0]             haddr,
  input  logic [9:0]             vaddr,
  input  logic                   game_over,
  input  logic                   goose_blink,
  input  logic [6:0]             jump_pos,
  input  logic [9:0]             scroll,
  input  logic [N_OBST-1:0]      obst_active,
  input  logic [10*N_OBST-1:0]   obst_x,
  output logic [1:0]             R,
  output logic [1:0]             G,
  output logic [1:0]             B,
  output logic                   coll_valid,
  output logic [N_OBST-1:0]      coll_mask,
  input  logic                   coll_ack
);
  localparam int GS = 16 << GOOSE_SCALE;
  function automatic logic [1:0] rom(input logic [3:0] x, input logic [3:0] y);
    rom = (y == 4'd1 && x == 4'd2) ? 2'd3 :
          (y < 4'd6 && x < 4'd6) ? 2'd1 :
          (y >= 4'd2 && y <= 4'd3 && x >= 4'd6 && x <= 4'd7) ? 2'd2 :
          (y >= 4'd6 && y < 4'd12) ? 2'd1 :
          (y >= 4'd12 && (x == 4'd4 || x == 4'd5 || x == 4'd9 || x == 4'd10)) ? 2'd2 : 2'd0;
  endfunction
  logic [10:0] h, v, gy;
  logic [3:0] rx, ry;
  logic [DOT_LOG2-1:0] ph;
  logic gx_hit, g_hit, g_op_d, dot_d, flr_d, sh_d;
  logic [1:0] g_idx_d;
  logic [N_OBST-1:0] o_hit_d, o_brd_d, hit_d;
  assign h = {1'b0, haddr};
  assign v = {1'b0, vaddr};
  assign gy = 11'(FLOOR_Y - GS) - {4'b0, jump_pos};
  assign rx = 4'((h - 11'(GOOSE_X)) >> GOOSE_SCALE);
  assign ry = 4'((v - gy) >> GOOSE_SCALE);
  assign gx_hit = h >= 11'(GOOSE_X) && h < 11'(GOOSE_X + GS);
  assign g_hit = gx_hit && v >= gy && v < gy + 11'(GS);
  assign g_idx_d = g_hit ? rom(rx, ry) : 2'd0;
  assign g_op_d = goose_blink && g_idx_d != 2'd0;
  for (genvar i = 0; i < N_OBST; i++) begin : g_obst
    logic [10:0] ox;
    assign ox = {1'b0, obst_x[10*i +: 10]};
    assign o_hit_d[i] = obst_active[i] && h >= ox && h < ox + 11'(OBST_W) && h < 11'd640 &&
                        v >= 11'(FLOOR_Y - OBST_H) && v < 11'(FLOOR_Y);
    assign o_brd_d[i] = h == ox || h == ox + 11'(OBST_W - 1) ||
                        v == 11'(FLOOR_Y - OBST_H) || v == 11'(FLOOR_Y - 1);
  end
  assign hit_d = o_hit_d & {N_OBST{g_op_d && display_on}};
  assign ph = DOT_LOG2'(haddr + scroll);
  assign dot_d = v == 11'(FLOOR_Y) && ph >= DOT_LOG2'(2) && ph <= DOT_LOG2'(5);
  assign flr_d = v >= 11'(FLOOR_Y);
`ifdef COMPOSITOR_SHADOW_EN
  assign sh_d = jump_pos != 7'd0 && v == 11'(FLOOR_Y + 1) && gx_hit;
`else
  assign sh_d = 1'b0;
`endif
  logic d_q, g_op_q, go_q, dot_q, flr_q, sh_q;
  logic [1:0] g_idx_q;
  logic [N_OBST-1:0] o_hit_q, o_brd_q, hit_q, mask_q, mask_d;
  logic [5:0] rgb_q, rgb_d, g_rgb, o_rgb;
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      {d_q, g_op_q, go_q, dot_q, flr_q, sh_q, g_idx_q} <= '0;
      {o_hit_q, o_brd_q, hit_q} <= '0;
    end else begin
      {d_q, g_op_q, go_q, dot_q, flr_q, sh_q, g_idx_q} <=
        {display_on, g_op_d, game_over, dot_d, flr_d, sh_d, g_idx_d};
      {o_hit_q, o_brd_q, hit_q} <= {o_hit_d, o_brd_d, hit_d};
    end
  end
  // lowest-index obstacle wins, so scan from the top down and let lower slots overwrite
  always_comb begin
    o_rgb = 6'b0;
    for (int i = N_OBST - 1; i >= 0; i--)
      if (o_hit_q[i]) o_rgb = o_brd_q[i] ? 6'b0 : 6'b111000;
    g_rgb = go_q ? 6'b100000 : g_idx_q == 2'd1 ? 6'b111111 : g_idx_q == 2'd2 ? 6'b110100 : 6'b0;
    rgb_d = !d_q ? 6'b0 : g_op_q ? g_rgb : |o_hit_q ? o_rgb : sh_q ? 6'b0 :
            dot_q ? 6'b101010 : flr_q ? 6'b010101 : 6'b001111;
    mask_d = (coll_ack ? '0 : mask_q) | hit_q;
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      rgb_q  <= '0;
      mask_q <= '0;
    end else begin
      rgb_q  <= rgb_d;
      mask_q <= mask_d;
    end
  end
  assign {R, G, B} = rgb_q;
  assign coll_mask = mask_q;
  assign coll_valid = |mask_q;
endmodule
